// File: rtl/pi_ctrl_pkg.sv
// Shared definitions for the phase-corrector PI loop control blocks:
// state encoding and default data/coefficient/counter widths.
package pi_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_TRK  = 2'd2
  } state_e;

endpackage

// File: rtl/pi_gain_scheduler_if.sv
// Phase-error sample stream from the phase detector into the gain scheduler.
interface pi_gain_scheduler_if #(
  parameter int NB_DATA = 16
);

  // err_valid is a one-cycle strobe qualifying err; there is no ready/backpressure,
  // so every strobed sample is consumed on the edge where err_valid is high.
  logic [NB_DATA-1:0] err;
  logic               err_valid;

  modport master (output err, output err_valid);
  modport slave  (input  err, input  err_valid);

endinterface

// File: rtl/pi_gain_scheduler_abs_sat.sv
// Combinational |x| of a two's-complement word; the most negative code
// saturates to the largest positive code instead of wrapping.
module abs_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] abs_o
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  always_comb begin
    if (!x_i[W-1])          abs_o = x_i;
    else if (x_i == MIN_NEG) abs_o = MAX_POS;
    else                    abs_o = -x_i;
  end

endmodule

// File: rtl/pi_gain_scheduler.sv
// Sequences the PI loop filter through IDLE/ACQUIRE/TRACK, selects the active
// Kp/Ki pair (plus K = Ki-Kp), detects lock/unlock and commands integrator clears.
module pi_gain_scheduler
  import pi_ctrl_pkg::*;
#(
  parameter int NB_DATA  = DATA_W,
  parameter int NB_COEF  = COEF_W,
  parameter int NB_CNT   = CNT_W,
  parameter int N_LOCK   = 64,
  parameter int N_UNLOCK = 8,
  parameter int T_ACQ    = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  pi_gain_scheduler_if.slave err_if,
  input  logic [NB_DATA-1:0] i_th_lock,
  input  logic [NB_DATA-1:0] i_th_unlock,
  input  logic [NB_COEF-1:0] i_kp_acq,
  input  logic [NB_COEF-1:0] i_ki_acq,
  input  logic [NB_COEF-1:0] i_kp_trk,
  input  logic [NB_COEF-1:0] i_ki_trk,
  output logic [NB_COEF-1:0] o_kp,
  output logic [NB_COEF-1:0] o_ki,
  output logic [NB_COEF-1:0] o_k,
  output logic               o_gain_upd,
  output logic               o_int_clr,
  output logic               o_locked,
  output logic               o_acq_fail,
  output logic [1:0]         o_state
);

  typedef logic [NB_CNT-1:0]  cnt_t;
  typedef logic [NB_COEF-1:0] coef_t;

  localparam cnt_t LOCK_N   = cnt_t'(N_LOCK);
  localparam cnt_t UNLOCK_N = cnt_t'(N_UNLOCK);
  localparam cnt_t TMO_N    = cnt_t'(T_ACQ);

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Ki-Kp on a 17-bit intermediate, then saturate back to the coefficient width.
  function automatic coef_t sat_trunc_fp(input coef_t ki, input coef_t kp);
    logic [NB_COEF:0] d;
    d = {ki[NB_COEF-1], ki} - {kp[NB_COEF-1], kp};
    if (d[NB_COEF] != d[NB_COEF-1]) return {d[NB_COEF], {(NB_COEF-1){~d[NB_COEF]}}};
    return d[NB_COEF-1:0];
  endfunction

  logic [NB_DATA-1:0] err_abs;
  logic               err_in, err_out, smp;
  coef_t              k_acq, k_trk;

  state_e state_q, state_d;
  cnt_t   lock_cnt_q, lock_cnt_d, unl_cnt_q, unl_cnt_d, tmo_cnt_q, tmo_cnt_d;
  coef_t  kp_q, kp_d, ki_q, ki_d, k_q, k_d;
  logic   gain_upd_q, gain_upd_d, int_clr_q, int_clr_d;
  logic   locked_q, locked_d, acq_fail_q, acq_fail_d;

  abs_sat #(.W(NB_DATA)) u_abs_sat (
    .x_i  (err_if.err),
    .abs_o(err_abs)
  );

  assign smp     = err_if.err_valid;
  assign err_in  = (err_abs <= i_th_lock);
  assign err_out = (err_abs > i_th_unlock);
  assign k_acq   = sat_trunc_fp(i_ki_acq, i_kp_acq);
  assign k_trk   = sat_trunc_fp(i_ki_trk, i_kp_trk);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unl_cnt_d  = unl_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    k_d        = k_q;
    gain_upd_d = 1'b0;
    int_clr_d  = 1'b0;
    locked_d   = locked_q;
    acq_fail_d = acq_fail_q;

    // A dropped enable wins over any transition decided on the same sample.
    if (!i_enable || (state_q != ST_ACQ && state_q != ST_TRK && state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
      unl_cnt_d  = '0;
      tmo_cnt_d  = '0;
      kp_d       = '0;
      ki_d       = '0;
      k_d        = '0;
      int_clr_d  = 1'b1;
      locked_d   = 1'b0;
      acq_fail_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQ;
          lock_cnt_d = '0;
          unl_cnt_d  = '0;
          tmo_cnt_d  = '0;
          kp_d       = i_kp_acq;
          ki_d       = i_ki_acq;
          k_d        = k_acq;
          gain_upd_d = 1'b1;
          acq_fail_d = 1'b0;
        end
        ST_ACQ: begin
          if (smp) begin
            lock_cnt_d = err_in ? sat_inc(lock_cnt_q) : '0;
            tmo_cnt_d  = sat_inc(tmo_cnt_q);
            if (lock_cnt_d == LOCK_N) begin
              state_d    = ST_TRK;
              lock_cnt_d = '0;
              tmo_cnt_d  = '0;
              unl_cnt_d  = '0;
              kp_d       = i_kp_trk;
              ki_d       = i_ki_trk;
              k_d        = k_trk;
              gain_upd_d = 1'b1;
              locked_d   = 1'b1;
            end else if (tmo_cnt_d == TMO_N) begin
              acq_fail_d = 1'b1;
              tmo_cnt_d  = '0;
            end
          end
        end
        default: begin
          // Samples inside the hysteresis band count as "not out" and restart the run.
          if (smp) begin
            unl_cnt_d = err_out ? sat_inc(unl_cnt_q) : '0;
            if (unl_cnt_d == UNLOCK_N) begin
              state_d    = ST_ACQ;
              unl_cnt_d  = '0;
              lock_cnt_d = '0;
              tmo_cnt_d  = '0;
              kp_d       = i_kp_acq;
              ki_d       = i_ki_acq;
              k_d        = k_acq;
              gain_upd_d = 1'b1;
              int_clr_d  = 1'b1;
              locked_d   = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      unl_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      k_q        <= '0;
      gain_upd_q <= 1'b0;
      int_clr_q  <= 1'b1;
      locked_q   <= 1'b0;
      acq_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      unl_cnt_q  <= unl_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      k_q        <= k_d;
      gain_upd_q <= gain_upd_d;
      int_clr_q  <= int_clr_d;
      locked_q   <= locked_d;
      acq_fail_q <= acq_fail_d;
    end
  end

  assign o_kp       = kp_q;
  assign o_ki       = ki_q;
  assign o_k        = k_q;
  assign o_gain_upd = gain_upd_q;
  assign o_int_clr  = int_clr_q;
  assign o_locked   = locked_q;
  assign o_acq_fail = acq_fail_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_pi_gain_scheduler.sv
// Self-checking bench for pi_gain_scheduler: gain-table vectors, timeout,
// hysteresis/unlock, abs saturation, enable override and mid-run reset.
module tb_pi_gain_scheduler;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_TRK  = 2'd2;
  localparam int NV = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] th_lock, th_unlock, kp_acq, ki_acq, kp_trk, ki_trk;
  logic [15:0] kp, ki, k;
  logic        gain_upd, int_clr, locked, acq_fail;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [49:0] exp_q[$];

  typedef struct {
    logic [15:0] kp_a, ki_a, kp_t, ki_t, k_a, k_t, err_in;
    int          gap;
  } vec_t;
  vec_t vecs[NV];

  pi_gain_scheduler_if #(.NB_DATA(16)) err_if ();

  pi_gain_scheduler dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enable   (enable),
    .err_if     (err_if),
    .i_th_lock  (th_lock),
    .i_th_unlock(th_unlock),
    .i_kp_acq   (kp_acq),
    .i_ki_acq   (ki_acq),
    .i_kp_trk   (kp_trk),
    .i_ki_trk   (ki_trk),
    .o_kp       (kp),
    .o_ki       (ki),
    .o_k        (k),
    .o_gain_upd (gain_upd),
    .o_int_clr  (int_clr),
    .o_locked   (locked),
    .o_acq_fail (acq_fail),
    .o_state    (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_k(input logic [15:0] ki_v, input logic [15:0] kp_v);
    int d;
    d = int'($signed(ki_v)) - int'($signed(kp_v));
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  // ---------------- scoreboard: every gain update pops one expectation ----------------
  always @(negedge clk) begin
    if (gain_upd === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_gain_upd", 64'd1, 64'd0);
      else check("gain_upd_set", 64'({state, kp, ki, k}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; err_if.err_valid = 1'b0; err_if.err = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_state", 64'(state), 64'(S_IDLE));
    check("rst_kp", 64'(kp), 64'd0);
    check("rst_ki", 64'(ki), 64'd0);
    check("rst_k", 64'(k), 64'd0);
    check("rst_int_clr", 64'(int_clr), 64'd1);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_acq_fail", 64'(acq_fail), 64'd0);
    check("rst_gain_upd", 64'(gain_upd), 64'd0);
  endtask

  task automatic start_acq(input logic [15:0] kpa, kia, kpt, kit, ka);
    kp_acq = kpa; ki_acq = kia; kp_trk = kpt; ki_trk = kit;
    enable = 1'b1;
    exp_q.push_back({S_ACQ, kpa, kia, ka});
    tick();
    check("acq_entry_state", 64'(state), 64'(S_ACQ));
    check("acq_entry_int_clr", 64'(int_clr), 64'd0);
  endtask

  task automatic send(input logic [15:0] e, input int gap);
    err_if.err = e; err_if.err_valid = 1'b1;
    tick();
    err_if.err_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_n(input logic [15:0] e, input int n, input int gap);
    for (int i = 0; i < n; i++) send(e, gap);
  endtask

  task automatic lock_up(input logic [15:0] e, input int gap, input logic [15:0] kt);
    send_n(e, 63, gap);
    check("pre_lock_state", 64'(state), 64'(S_ACQ));
    exp_q.push_back({S_TRK, kp_trk, ki_trk, kt});
    send(e, 0);
    check("lock_state", 64'(state), 64'(S_TRK));
    check("lock_locked", 64'(locked), 64'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; err_if.err = '0; err_if.err_valid = 1'b0;
    th_lock = 16'h0100; th_unlock = 16'h0400;
    kp_acq = '0; ki_acq = '0; kp_trk = '0; ki_trk = '0;

    // kp_a, ki_a, kp_t, ki_t, k_a, k_t, err_in, gap
    vecs[0] = '{16'h0400, 16'h0100, 16'h0080, 16'h0010, 16'hFD00, 16'hFF90, 16'h0000, 3};
    vecs[1] = '{16'h1000, 16'h2000, 16'h7FFF, 16'h8000, 16'h1000, 16'h8000, 16'h0100, 0};
    vecs[2] = '{16'h0001, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFF00, 0};
    vecs[3] = '{16'h4000, 16'hC000, 16'hC000, 16'h4000, 16'h8000, 16'h7FFF, 16'h00FF, 0};
    vecs[4] = '{16'h0000, 16'h0000, 16'hC001, 16'h3FFF, 16'h0000, 16'h7FFE, 16'hFF01, 0};
    for (int v = 5; v < NV; v++) begin
      vecs[v].kp_a = 16'($urandom_range(0, 65535));
      vecs[v].ki_a = 16'($urandom_range(0, 65535));
      vecs[v].kp_t = 16'($urandom_range(0, 65535));
      vecs[v].ki_t = 16'($urandom_range(0, 65535));
      vecs[v].k_a  = model_k(vecs[v].ki_a, vecs[v].kp_a);
      vecs[v].k_t  = model_k(vecs[v].ki_t, vecs[v].kp_t);
      vecs[v].err_in = 16'($urandom_range(0, 256));
      vecs[v].gap  = 1;
    end

    do_reset();
    check_reset_vals();

    // Acquisition -> tracking for each gain vector.
    for (int v = 0; v < NV; v++) begin
      do_reset();
      start_acq(vecs[v].kp_a, vecs[v].ki_a, vecs[v].kp_t, vecs[v].ki_t, vecs[v].k_a);
      check("acq_kp", 64'(kp), 64'(vecs[v].kp_a));
      check("acq_k", 64'(k), 64'(vecs[v].k_a));
      lock_up(vecs[v].err_in, vecs[v].gap, vecs[v].k_t);
      check("trk_kp", 64'(kp), 64'(vecs[v].kp_t));
      check("trk_ki", 64'(ki), 64'(vecs[v].ki_t));
      check("trk_k", 64'(k), 64'(vecs[v].k_t));
    end

    // Acquisition timeout: 63 in / 1 out never locks; flag after the 1000th sample.
    do_reset();
    start_acq(16'h0200, 16'h0300, 16'h0020, 16'h0030, 16'h0100);
    for (int i = 0; i < 1100; i++) begin
      send((i % 64 == 63) ? 16'h0800 : 16'h0000, 0);
      if (i == 998) check("tmo_before", 64'(acq_fail), 64'd0);
      if (i == 999) begin
        check("tmo_flag", 64'(acq_fail), 64'd1);
        check("tmo_state", 64'(state), 64'(S_ACQ));
      end
    end
    check("tmo_sticky", 64'(acq_fail), 64'd1);
    check("tmo_no_lock", 64'(locked), 64'd0);
    enable = 1'b0;
    tick();
    check("tmo_idle_state", 64'(state), 64'(S_IDLE));
    check("tmo_idle_flag", 64'(acq_fail), 64'd0);
    check("tmo_idle_int_clr", 64'(int_clr), 64'd1);

    // Tracking hysteresis and unlock.
    do_reset();
    start_acq(16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0100);
    lock_up(16'h0000, 0, 16'h0010);
    send_n(16'h0200, 8, 0);
    check("band_stays_trk", 64'(state), 64'(S_TRK));
    send_n(16'h0800, 7, 0);
    send(16'h0400, 0);
    kp_trk = 16'h1234;
    kp_acq = 16'h0555;
    send_n(16'h0800, 7, 0);
    check("hyst_reset_trk", 64'(state), 64'(S_TRK));
    check("trk_kp_held", 64'(kp), 64'h0010);
    exp_q.push_back({S_ACQ, 16'h0555, 16'h0200, model_k(16'h0200, 16'h0555)});
    send(16'h0800, 0);
    check("unlock_state", 64'(state), 64'(S_ACQ));
    check("unlock_int_clr", 64'(int_clr), 64'd1);
    check("unlock_locked", 64'(locked), 64'd0);
    tick();
    check("unlock_int_clr_pulse", 64'(int_clr), 64'd0);

    // -32768 is |32767|: inside a 0x7FFF lock threshold, not above a 0x7FFF unlock one.
    th_lock = 16'h7FFF; th_unlock = 16'h7FFF;
    do_reset();
    start_acq(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0001);
    lock_up(16'h8000, 0, 16'h0001);
    send_n(16'h8000, 8, 0);
    check("absmin_not_out", 64'(state), 64'(S_TRK));
    th_lock = 16'h0100; th_unlock = 16'h7FFE;
    do_reset();
    start_acq(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0001);
    lock_up(16'h0000, 0, 16'h0001);
    send_n(16'h8000, 7, 0);
    exp_q.push_back({S_ACQ, 16'h0001, 16'h0002, 16'h0001});
    send(16'h8000, 0);
    check("absmin_out", 64'(state), 64'(S_ACQ));
    th_unlock = 16'h0400;

    // Enable drop on the locking sample: IDLE wins.
    do_reset();
    start_acq(16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0100);
    send_n(16'h0000, 63, 0);
    err_if.err = 16'h0000; err_if.err_valid = 1'b1; enable = 1'b0;
    tick();
    err_if.err_valid = 1'b0;
    check("en_drop_state", 64'(state), 64'(S_IDLE));
    check("en_drop_kp", 64'(kp), 64'd0);
    check("en_drop_k", 64'(k), 64'd0);
    check("en_drop_int_clr", 64'(int_clr), 64'd1);
    check("en_drop_locked", 64'(locked), 64'd0);
    tick();
    check("en_drop_hold", 64'(state), 64'(S_IDLE));

    // Reset mid-TRACK.
    do_reset();
    start_acq(16'h0100, 16'h0200, 16'h0010, 16'h0020, 16'h0100);
    lock_up(16'h0000, 0, 16'h0010);
    send_n(16'h0200, 3, 0);
    rst = 1'b1; err_if.err = 16'h0800; err_if.err_valid = 1'b1;
    tick();
    err_if.err_valid = 1'b0;
    check_reset_vals();
    rst = 1'b0;
    exp_q.push_back({S_ACQ, 16'h0100, 16'h0200, 16'h0100});
    tick();
    check("post_rst_acq", 64'(state), 64'(S_ACQ));

    enable = 1'b0;
    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
